fetch_seq: RTL
==============

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 The block SHALL have parameter PC_INIT, default 32'h0000_3000, meaning the reset PC and base byte address of instruction memory.
REQ-002 The block SHALL have parameter IM_WORDS, default 4096, meaning the instruction-memory depth in 32-bit words.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- stall  in  1  hold the current PC this cycle.
- br_take  in  1  conditional branch resolved taken.
- br_imm  in  16  signed branch word offset.
- jump  in  1  j/jal redirect.
- j_index  in  26  jump index field.
- jr  in  1  register-indirect redirect.
- jr_target  in  32  jr byte target.
- halt_req  in  1  request to stop fetching.
- pc  out  32  current fetch byte address.
- pc_plus4  out  32  pc + 4, used as the jal link value.
- fetch_valid  out  1  pc holds a fetchable instruction this cycle.
- halted  out  1  block is in HALT.
- addr_err  out  1  sticky flag: a bad redirect target was detected.
- icount  out  32  count of instructions advanced past.

Function
REQ-004 The block SHALL implement FSM states BOOT, RUN and HALT with these transitions:
- BOOT -> RUN unconditionally after 1 cycle.
- RUN -> HALT on halt_req or on an address error.
- HALT is absorbing until reset.
REQ-005 fetch_valid SHALL equal (state==RUN), and halted SHALL equal (state==HALT).
REQ-006 pc_plus4 SHALL be pc+4 computed modulo 2^32.
REQ-007 The next-PC source SHALL be selected by priority jr > jump > br_take > pc_plus4.
REQ-008 The branch target SHALL be pc_plus4 + (sign-extended br_imm << 2), in 32-bit wrap-around arithmetic.
REQ-009 The jump target SHALL be {pc_plus4[31:28], j_index, 2'b00}.
REQ-010 In RUN with stall=0 and no halt or error, pc SHALL load the selected next PC and icount SHALL increment by 1, saturating at 32'hFFFF_FFFF; PC update latency is 1 cycle.
REQ-011 In RUN with stall=1, pc and icount SHALL hold, and any asserted redirect SHALL be captured into a pending-redirect register (target plus valid bit), with a later redirect overwriting an earlier one.
REQ-012 On the first RUN cycle with stall=0, a pending redirect SHALL be used as the next PC unless a new redirect is asserted that cycle, in which case the new redirect SHALL win; the pending valid bit SHALL then clear.
REQ-013 A target SHALL be illegal if target[1:0]!=0, target < PC_INIT, or target >= PC_INIT + 4*IM_WORDS.
REQ-014 When an illegal target would be loaded, pc SHALL hold, addr_err SHALL be set, and the next state SHALL be HALT. The check SHALL apply at capture time for stalled redirects.
REQ-015 Sequential fall-through from the last word SHALL be treated as an illegal target.
REQ-016 When halt_req and a redirect are asserted in the same cycle, halt_req SHALL win: pc holds and the state goes to HALT. halt_req SHALL be honoured even while stall=1.
REQ-017 In BOOT and HALT, all inputs except reset SHALL be ignored, and pc and icount SHALL hold.

Reset
REQ-018 Assertion of reset SHALL immediately force the following, independent of clk, including mid-stall or mid-pending-redirect:
- pc = PC_INIT
- state = BOOT, so fetch_valid=0 and halted=0
- addr_err = 0
- icount = 0
- pending valid = 0
REQ-019 After reset deasserts, the first rising edge SHALL move the FSM BOOT -> RUN, and fetch_valid SHALL rise in that cycle.

Structure
REQ-020 A shared package SHALL hold PC_INIT, IM_WORDS, the FSM state encoding, and the redirect-source encoding (NONE, BR, J, JR).
REQ-021 Target computation and the legality check SHALL be a combinational sub-module named npc_calc; the FSM, PC, pending and counter registers SHALL reside in fetch_seq.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Reset then 3 free cycles -> pc sequence 3000, 3000(BOOT), 3004, 3008; icount=2; fetch_valid 0 then 1.
- At pc=3010, br_take=1, br_imm=16'hFFFC -> next pc=3004; with jump=1 and j_index=26'h0000C10 in the same cycle -> pc=3040 (jump beats branch).
- stall=1 for 3 cycles at pc=3020 with jr=1, jr_target=3100 in the first stall cycle -> pc holds at 3020, then pc=3100 on the first unstalled cycle; icount unchanged during the stall.
- jr_target=3102 (misaligned) or jr_target=7000 (out of range) -> pc holds, addr_err=1, halted=1 next cycle; later inputs are ignored.
- halt_req=1 together with jump=1 -> halted=1, pc unchanged; reset asserted mid-HALT -> immediate pc=3000, addr_err=0, halted=0.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: shared definitions for the instruction-fetch sequencer.
//   PC_INIT_DEF / IM_WORDS_DEF : default reset PC and instruction-memory depth
//   state_t                    : sequencer FSM encoding (BOOT, RUN, HALT)
//   redir_t                    : source of a redirect asserted this cycle
package fetch_seq_pkg;

    localparam logic [31:0] PC_INIT_DEF  = 32'h0000_3000;
    localparam int unsigned IM_WORDS_DEF = 4096;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_BR   = 2'd1,
        SRC_J    = 2'd2,
        SRC_JR   = 2'd3
    } redir_t;

endpackage

// File: rtl/fetch_seq_npc.sv
// npc_calc: combinational next-PC selection and target legality check.
//   Inputs : pc, branch/jump/jr redirect requests with their operands,
//            the pending (stall-captured) redirect target and valid bit.
//   Outputs: pc_plus4, new_src (redirect asserted this cycle, priority
//            jr > jump > branch), sel_tgt (new redirect, else pending,
//            else pc_plus4) and illegal (sel_tgt outside instruction memory
//            or misaligned).
module npc_calc
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] PC_INIT  = PC_INIT_DEF,
    parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
    input  logic               [31:0] pc,
    input  logic                      br_take,
    input  logic signed        [15:0] br_imm,
    input  logic                      jump,
    input  logic               [25:0] j_index,
    input  logic                      jr,
    input  logic               [31:0] jr_target,
    input  logic                      pend_vld,
    input  logic               [31:0] pend_tgt,
    output logic               [31:0] pc_plus4,
    output redir_t                    new_src,
    output logic               [31:0] sel_tgt,
    output logic                      illegal
);

    // One past the last legal byte address; 33 bits so the sum cannot wrap.
    localparam logic [32:0] IM_END = {1'b0, PC_INIT} + (33'(IM_WORDS) << 2);

    function automatic logic tgt_illegal(input logic [31:0] t);
        return (t[1:0] != 2'b00) || (t < PC_INIT) || ({1'b0, t} >= IM_END);
    endfunction

    logic signed [31:0] br_off;
    logic        [31:0] br_tgt;
    logic        [31:0] j_tgt;

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{br_imm[15]}}, br_imm, 2'b00};
    assign br_tgt   = pc_plus4 + br_off;
    assign j_tgt    = {pc_plus4[31:28], j_index, 2'b00};

    always_comb begin
        new_src = SRC_NONE;
        if (jr)
            new_src = SRC_JR;
        else if (jump)
            new_src = SRC_J;
        else if (br_take)
            new_src = SRC_BR;
    end

    // A redirect asserted this cycle beats a pending one; sequential
    // fall-through is checked like any other target so running off the
    // end of memory is caught.
    always_comb begin
        sel_tgt = pc_plus4;
        case (new_src)
            SRC_JR:   sel_tgt = jr_target;
            SRC_J:    sel_tgt = j_tgt;
            SRC_BR:   sel_tgt = br_tgt;
            default:  sel_tgt = pend_vld ? pend_tgt : pc_plus4;
        endcase
    end

    assign illegal = tgt_illegal(sel_tgt);

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch PC sequencer with BOOT/RUN/HALT control.
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   stall           : hold pc; redirects seen while stalled are remembered
//   br_take/br_imm  : taken conditional branch, signed word offset
//   jump/j_index    : j/jal redirect
//   jr/jr_target    : register-indirect redirect
//   halt_req        : stop fetching
//   pc, pc_plus4    : current fetch address and its link value
//   fetch_valid     : in RUN; halted : in HALT
//   addr_err        : sticky, set when a bad target was seen
//   icount          : saturating count of instructions advanced past
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] PC_INIT  = PC_INIT_DEF,
    parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               br_take,
    input  logic signed [15:0] br_imm,
    input  logic               jump,
    input  logic        [25:0] j_index,
    input  logic               jr,
    input  logic        [31:0] jr_target,
    input  logic               halt_req,
    output logic        [31:0] pc,
    output logic        [31:0] pc_plus4,
    output logic               fetch_valid,
    output logic               halted,
    output logic               addr_err,
    output logic        [31:0] icount
);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t      state;
    logic        pend_vld;
    logic [31:0] pend_tgt;
    redir_t      new_src;
    logic [31:0] sel_tgt;
    logic        illegal;
    logic        redir;
    logic        capture;

    npc_calc #(
        .PC_INIT  (PC_INIT),
        .IM_WORDS (IM_WORDS)
    ) u_npc (
        .pc        (pc),
        .br_take   (br_take),
        .br_imm    (br_imm),
        .jump      (jump),
        .j_index   (j_index),
        .jr        (jr),
        .jr_target (jr_target),
        .pend_vld  (pend_vld),
        .pend_tgt  (pend_tgt),
        .pc_plus4  (pc_plus4),
        .new_src   (new_src),
        .sel_tgt   (sel_tgt),
        .illegal   (illegal)
    );

    assign redir   = (new_src != SRC_NONE);
    // Stalled redirect that passes the legality check is remembered.
    assign capture = (state == ST_RUN) && stall && !halt_req && redir && !illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_BOOT;
            pc          <= PC_INIT;
            icount      <= '0;
            addr_err    <= 1'b0;
            pend_vld    <= 1'b0;
            fetch_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state       <= ST_RUN;
                    fetch_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state       <= ST_HALT;
                        fetch_valid <= 1'b0;
                        halted      <= 1'b1;
                    end else if (stall) begin
                        if (redir) begin
                            if (illegal) begin
                                addr_err    <= 1'b1;
                                state       <= ST_HALT;
                                fetch_valid <= 1'b0;
                                halted      <= 1'b1;
                            end else begin
                                pend_vld <= 1'b1;
                            end
                        end
                    end else begin
                        pend_vld <= 1'b0;
                        if (illegal) begin
                            addr_err    <= 1'b1;
                            state       <= ST_HALT;
                            fetch_valid <= 1'b0;
                            halted      <= 1'b1;
                        end else begin
                            pc     <= sel_tgt;
                            icount <= sat_inc(icount);
                        end
                    end
                end
                default: begin
                    // HALT: absorbing until reset.
                    state       <= ST_HALT;
                    fetch_valid <= 1'b0;
                    halted      <= 1'b1;
                end
            endcase
        end
    end

    // Pending target is qualified by pend_vld, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture)
            pend_tgt <= sel_tgt;
    end

endmodule
